// File: rtl/alu_pkg.sv
// Shared widths, opcodes and arbiter state encodings for the ALU arbiter slice.
package alu_pkg;

  localparam int DATA_W = 8;
  localparam int OP_W   = 3;
  localparam int FLAG_W = 4;

  // ALU opcodes
  localparam logic [OP_W-1:0] OP_ADD  = 3'd0;
  localparam logic [OP_W-1:0] OP_SUB  = 3'd1;
  localparam logic [OP_W-1:0] OP_AND  = 3'd2;
  localparam logic [OP_W-1:0] OP_OR   = 3'd3;
  localparam logic [OP_W-1:0] OP_XOR  = 3'd4;
  localparam logic [OP_W-1:0] OP_SHL  = 3'd5;
  localparam logic [OP_W-1:0] OP_SHR  = 3'd6;
  localparam logic [OP_W-1:0] OP_PASS = 3'd7;

  // Arbiter FSM states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/alu_arbiter_alu.sv
// Combinational 8-bit ALU producing a result and {N,Z,V,C} flags.
// SUB reports C as a borrow (set when a < b unsigned); shifts report the
// bit shifted out in C; logic ops and PASS (result = b) clear V and C.
module alu
  import alu_pkg::*;
(
  output logic [DATA_W-1:0] result,
  output logic [FLAG_W-1:0] nzvc,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [OP_W-1:0]   op
);

  logic [DATA_W:0] sum_ext;
  logic            carry;
  logic            ovf;

  // Operation select plus flag generation
  always_comb begin
    result  = '0;
    sum_ext = '0;
    carry   = 1'b0;
    ovf     = 1'b0;
    case (op)
      OP_ADD: begin
        sum_ext = {1'b0, a} + {1'b0, b};
        result  = sum_ext[DATA_W-1:0];
        carry   = sum_ext[DATA_W];
        ovf     = (a[DATA_W-1] == b[DATA_W-1]) && (result[DATA_W-1] != a[DATA_W-1]);
      end
      OP_SUB: begin
        sum_ext = {1'b0, a} - {1'b0, b};
        result  = sum_ext[DATA_W-1:0];
        carry   = sum_ext[DATA_W];
        ovf     = (a[DATA_W-1] != b[DATA_W-1]) && (result[DATA_W-1] != a[DATA_W-1]);
      end
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_SHL: begin
        result = {a[DATA_W-2:0], 1'b0};
        carry  = a[DATA_W-1];
      end
      OP_SHR: begin
        result = {1'b0, a[DATA_W-1:1]};
        carry  = a[0];
      end
      OP_PASS: result = b;
      default: result = '0;
    endcase
    nzvc = {result[DATA_W-1], (result == '0), ovf, carry};
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter time-sharing one ALU between two requesters.
// Each operation walks IDLE (accept) -> EXEC (compute/register) -> RESP
// (hold until the consumer takes it), so at most one op is in flight.
module alu_arbiter
  import alu_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [OP_W-1:0]   req0_op,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic [OP_W-1:0]   req1_op,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_result,
  output logic [FLAG_W-1:0] rsp_nzvc
);

  state_e              state_q, state_d;
  logic                last_grant_q, last_grant_d;
  logic [DATA_W-1:0]   op_a_q, op_a_d;
  logic [DATA_W-1:0]   op_b_q, op_b_d;
  logic [OP_W-1:0]     op_code_q, op_code_d;
  logic                op_id_q, op_id_d;
  logic [DATA_W-1:0]   rsp_result_q, rsp_result_d;
  logic [FLAG_W-1:0]   rsp_nzvc_q, rsp_nzvc_d;
  logic                rsp_id_q, rsp_id_d;
  logic                grant0, grant1;
  logic [DATA_W-1:0]   alu_result;
  logic [FLAG_W-1:0]   alu_nzvc;

  // Round-robin grant, only offered from IDLE and never while reset is held
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if ((state_q == IDLE) && rst_n) begin
      if (req0_valid && req1_valid) begin
        grant0 = last_grant_q;
        grant1 = ~last_grant_q;
      end else begin
        grant0 = req0_valid;
        grant1 = req1_valid;
      end
    end
  end

  // Single shared ALU fed straight from the latched operands
  alu u_alu (
    .result (alu_result),
    .nzvc   (alu_nzvc),
    .a      (op_a_q),
    .b      (op_b_q),
    .op     (op_code_q)
  );

  // Next-state and datapath-load decisions
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    op_a_d       = op_a_q;
    op_b_d       = op_b_q;
    op_code_d    = op_code_q;
    op_id_d      = op_id_q;
    rsp_result_d = rsp_result_q;
    rsp_nzvc_d   = rsp_nzvc_q;
    rsp_id_d     = rsp_id_q;
    case (state_q)
      IDLE: begin
        if (grant0 || grant1) begin
          op_a_d       = grant1 ? req1_a  : req0_a;
          op_b_d       = grant1 ? req1_b  : req0_b;
          op_code_d    = grant1 ? req1_op : req0_op;
          op_id_d      = grant1;
          last_grant_d = grant1;
          state_d      = EXEC;
        end
      end
      EXEC: begin
        rsp_result_d = alu_result;
        rsp_nzvc_d   = alu_nzvc;
        rsp_id_d     = op_id_q;
        state_d      = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; last grant resets to 1 so requester 0 wins first
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      op_a_q       <= '0;
      op_b_q       <= '0;
      op_code_q    <= '0;
      op_id_q      <= 1'b0;
      rsp_result_q <= '0;
      rsp_nzvc_q   <= '0;
      rsp_id_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      op_a_q       <= op_a_d;
      op_b_q       <= op_b_d;
      op_code_q    <= op_code_d;
      op_id_q      <= op_id_d;
      rsp_result_q <= rsp_result_d;
      rsp_nzvc_q   <= rsp_nzvc_d;
      rsp_id_q     <= rsp_id_d;
    end
  end

  // Handshake outputs decode from state only
  always_comb begin
    req0_ready = grant0;
    req1_ready = grant1;
    rsp_valid  = (state_q == RESP);
    rsp_id     = rsp_id_q;
    rsp_result = rsp_result_q;
    rsp_nzvc   = rsp_nzvc_q;
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed scenarios followed by random traffic,
// all compared against a transaction-level model of the arbiter and ALU.
module tb_alu_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req0_valid, req0_ready, req1_valid, req1_ready;
  logic [7:0] req0_a, req0_b, req1_a, req1_b;
  logic [2:0] req0_op, req1_op;
  logic       rsp_valid, rsp_ready, rsp_id;
  logic [7:0] rsp_result;
  logic [3:0] rsp_nzvc;

  typedef struct {
    int         cyc;
    bit         id;
    logic [7:0] result;
    logic [3:0] nzvc;
  } rsp_rec_t;

  int assert_cnt = 0;
  int fail_cnt   = 0;
  int cyc        = 0;

  // Model: one op in flight, response due two cycles after acceptance
  bit         m_busy;
  int         m_accept_cyc;
  bit         m_last;
  bit         m_id;
  logic [7:0] m_res;
  logic [3:0] m_flags;
  int         grant_log[$];
  int         grant_cyc[$];
  rsp_rec_t   rsp_log[$];

  alu_arbiter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_op    (req0_op),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_op    (req1_op),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .rsp_nzvc   (rsp_nzvc)
  );

  always #5 clk = ~clk;

  // Reference ALU computed with plain integer arithmetic; returns {result, N, Z, V, C}
  function automatic logic [11:0] ref_alu(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
    int ua, ub, sa, sb, full, sres;
    logic [7:0] r;
    bit c, v;
    ua = a; ub = b;
    sa = (ua >= 128) ? ua - 256 : ua;
    sb = (ub >= 128) ? ub - 256 : ub;
    c = 0; v = 0; r = 8'h00;
    case (op)
      3'd0: begin full = ua + ub; r = 8'(full % 256); c = (full > 255);
                  sres = sa + sb; v = (sres > 127) || (sres < -128); end
      3'd1: begin full = ua - ub + 256; r = 8'(full % 256); c = (ua < ub);
                  sres = sa - sb; v = (sres > 127) || (sres < -128); end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      3'd5: begin r = 8'((ua * 2) % 256); c = (ua >= 128); end
      3'd6: begin r = 8'(ua / 2); c = (ua % 2) == 1; end
      default: r = b;
    endcase
    return {r, (r >= 8'd128), (r == 8'd0), v, c};
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    assert_cnt++;
    assert (obs === exp) else begin
      fail_cnt++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Compare outputs with model expectations, then advance the model across the edge
  task automatic checkOutput();
    bit exp_r0, exp_r1, exp_rv;
    logic [11:0] calc;
    exp_r0 = 0; exp_r1 = 0;
    if (!m_busy) begin
      if (req0_valid && req1_valid) begin
        if (m_last) exp_r0 = 1; else exp_r1 = 1;
      end else if (req0_valid) exp_r0 = 1;
      else if (req1_valid) exp_r1 = 1;
    end
    exp_rv = m_busy && (cyc >= m_accept_cyc + 2);
    check("req0_ready", 16'(req0_ready), 16'(exp_r0));
    check("req1_ready", 16'(req1_ready), 16'(exp_r1));
    check("rsp_valid", 16'(rsp_valid), 16'(exp_rv));
    if (exp_rv) begin
      check("rsp_result", 16'(rsp_result), 16'(m_res));
      check("rsp_nzvc", 16'(rsp_nzvc), 16'(m_flags));
      check("rsp_id", 16'(rsp_id), 16'(m_id));
    end
    if (rsp_valid && rsp_ready)
      rsp_log.push_back('{cyc: cyc, id: rsp_id, result: rsp_result, nzvc: rsp_nzvc});
    if (exp_rv && rsp_ready) begin
      m_busy = 0;
    end else if (!m_busy && (exp_r0 || exp_r1)) begin
      m_busy       = 1;
      m_accept_cyc = cyc;
      m_id         = exp_r1;
      m_last       = exp_r1;
      calc = exp_r1 ? ref_alu(req1_a, req1_b, req1_op) : ref_alu(req0_a, req0_b, req0_op);
      {m_res, m_flags} = calc;
      grant_log.push_back(int'(exp_r1));
      grant_cyc.push_back(cyc);
    end
  endtask

  // One clock cycle: drive just after the rising edge, check on the falling edge
  task automatic applyStimulus(input logic v0, input logic v1,
                               input logic [7:0] a0, input logic [7:0] b0, input logic [2:0] op0,
                               input logic [7:0] a1, input logic [7:0] b1, input logic [2:0] op1,
                               input logic rr);
    req0_valid = v0; req0_a = a0; req0_b = b0; req0_op = op0;
    req1_valid = v1; req1_a = a1; req1_b = b1; req1_op = op1;
    rsp_ready  = rr;
    @(negedge clk);
    checkOutput();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++)
      applyStimulus(0, 0, 8'($urandom), 8'($urandom), 3'($urandom),
                    8'($urandom), 8'($urandom), 3'($urandom), 1);
  endtask

  // Asynchronous reset entered between edges; outputs must clear without a clock
  task automatic doReset(input logic v0, input logic v1);
    req0_valid = v0; req1_valid = v1;
    rst_n = 1'b0;
    #1;
    check("rst_rsp_valid", 16'(rsp_valid), 16'h0);
    check("rst_req0_ready", 16'(req0_ready), 16'h0);
    check("rst_req1_ready", 16'(req1_ready), 16'h0);
    check("rst_rsp_result", 16'(rsp_result), 16'h00);
    check("rst_rsp_nzvc", 16'(rsp_nzvc), 16'h0);
    check("rst_rsp_id", 16'(rsp_id), 16'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    req0_valid = 0; req1_valid = 0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    m_busy = 0;
    m_last = 1;
  endtask

  initial begin
    int t0, s, r0;
    req0_valid = 0; req1_valid = 0; rsp_ready = 0;
    req0_a = 0; req0_b = 0; req0_op = 0; req1_a = 0; req1_b = 0; req1_op = 0;
    rst_n = 1;
    m_busy = 0; m_last = 1; m_accept_cyc = 0; m_id = 0; m_res = 0; m_flags = 0;
    #2;
    $display("[TB] reset from power-up");
    doReset(0, 0);

    // Single ADD 1+1 from requester 0
    $display("[TB] single operation");
    t0 = cyc;
    r0 = rsp_log.size();
    applyStimulus(1, 0, 8'h01, 8'h01, 3'b000, 8'h00, 8'h00, 3'b000, 1);
    applyStimulus(0, 0, 8'h00, 8'h00, 3'b000, 8'h00, 8'h00, 3'b000, 1);
    applyStimulus(0, 0, 8'h00, 8'h00, 3'b000, 8'h00, 8'h00, 3'b000, 1);
    check("single_grant_cyc", 16'(grant_cyc[$] - t0), 16'd0);
    check("single_rsp_count", 16'(rsp_log.size() - r0), 16'd1);
    check("single_rsp_cyc", 16'(rsp_log[$].cyc - t0), 16'd2);
    check("single_result", 16'(rsp_log[$].result), 16'h02);
    check("single_nzvc", 16'(rsp_log[$].nzvc), 16'h0);
    check("single_id", 16'(rsp_log[$].id), 16'h0);

    // Both requesters contending from reset
    $display("[TB] contention");
    doReset(0, 0);
    r0 = rsp_log.size();
    for (int i = 0; i < 12; i++)
      applyStimulus(1, 1, 8'($urandom), 8'($urandom), 3'($urandom),
                    8'($urandom), 8'($urandom), 3'($urandom), 1);
    check("contend_rsp_count", 16'(rsp_log.size() - r0), 16'd4);
    for (int i = 0; i < 4; i++)
      if (r0 + i < rsp_log.size())
        check($sformatf("contend_id%0d", i), 16'(rsp_log[r0 + i].id), 16'(i % 2));

    // Back-pressure: five stalled RESP cycles while requester 1 waits
    $display("[TB] back-pressure");
    idleCycles(4);
    t0 = cyc;
    applyStimulus(1, 0, 8'h35, 8'h4C, 3'd1, 8'h00, 8'h00, 3'd0, 0);
    for (int i = 0; i < 6; i++)
      applyStimulus(1, 1, 8'($urandom), 8'($urandom), 3'($urandom), 8'h0F, 8'hF0, 3'd3, 0);
    applyStimulus(0, 1, 8'h00, 8'h00, 3'd0, 8'h0F, 8'hF0, 3'd3, 1);
    applyStimulus(0, 1, 8'h00, 8'h00, 3'd0, 8'h0F, 8'hF0, 3'd3, 1);
    check("bp_grant_id", 16'(grant_log[$]), 16'd1);
    check("bp_grant_cyc", 16'(grant_cyc[$] - t0), 16'd8);
    idleCycles(3);

    // Operand hold: requester 0 inputs change right after acceptance
    $display("[TB] operand hold");
    applyStimulus(1, 0, 8'h10, 8'h05, 3'd0, 8'h00, 8'h00, 3'd0, 1);
    applyStimulus(1, 0, 8'hFF, 8'hFF, 3'd7, 8'h00, 8'h00, 3'd0, 1);
    applyStimulus(0, 0, 8'hAA, 8'h55, 3'd4, 8'h00, 8'h00, 3'd0, 1);
    check("hold_result", 16'(rsp_log[$].result), 16'h15);
    idleCycles(4);

    // Reset while a response is waiting
    $display("[TB] reset mid-response");
    applyStimulus(1, 0, 8'h80, 8'h80, 3'd0, 8'h00, 8'h00, 3'd0, 0);
    applyStimulus(0, 0, 8'h00, 8'h00, 3'd0, 8'h00, 8'h00, 3'd0, 0);
    applyStimulus(0, 0, 8'h00, 8'h00, 3'd0, 8'h00, 8'h00, 3'd0, 0);
    check("pre_reset_rsp_valid", 16'(rsp_valid), 16'h1);
    r0 = rsp_log.size();
    doReset(1, 1);
    idleCycles(6);
    check("post_reset_no_rsp", 16'(rsp_log.size() - r0), 16'd0);

    // Requester 1 streaming alone
    $display("[TB] single requester streaming");
    s = grant_log.size();
    r0 = rsp_log.size();
    for (int i = 0; i < 12; i++)
      applyStimulus(0, 1, 8'h00, 8'h00, 3'd0, 8'($urandom), 8'($urandom), 3'($urandom), 1);
    check("stream_grant_count", 16'(grant_log.size() - s), 16'd4);
    check("stream_rsp_count", 16'(rsp_log.size() - r0), 16'd4);
    for (int i = 0; i < 4; i++) begin
      if (s + i < grant_log.size()) begin
        check($sformatf("stream_grant_id%0d", i), 16'(grant_log[s + i]), 16'd1);
        if (i > 0)
          check($sformatf("stream_spacing%0d", i), 16'(grant_cyc[s + i] - grant_cyc[s + i - 1]), 16'd3);
      end
      if (r0 + i < rsp_log.size())
        check($sformatf("stream_rsp_id%0d", i), 16'(rsp_log[r0 + i].id), 16'd1);
    end

    // Random traffic against the model
    $display("[TB] random traffic");
    for (int i = 0; i < 400; i++)
      applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    8'($urandom), 8'($urandom), 3'($urandom),
                    8'($urandom), 8'($urandom), 3'($urandom),
                    1'($urandom_range(0, 3) != 0));

    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 clk  input  1  single clock; all state updates on its rising edge.
REQ-002 rst_n  input  1  reset, asynchronous, active-low.
REQ-003 req0_valid  input  1  requester 0 has an operation pending.
REQ-004 req0_ready  output  1  requester 0 operation accepted this cycle.
REQ-005 req0_a, req0_b  input  8 each  requester 0 operands.
REQ-006 req0_op  input  3  requester 0 ALU opcode.
REQ-007 req1_valid, req1_ready, req1_a, req1_b, req1_op  same widths/meaning as REQ-003..006 for requester 1.
REQ-008 rsp_valid  output  1  response registers hold a completed operation.
REQ-009 rsp_ready  input  1  consumer takes the response this cycle.
REQ-010 rsp_id  output  1  requester that issued the response (0/1).
REQ-011 rsp_result  output  8  registered ALU result.
REQ-012 rsp_nzvc  output  4  registered ALU flags {N,Z,V,C}.

Function
REQ-013 Block SHALL time-share one combinational ALU instance between two requesters; opcode and operands pass to the ALU unmodified.
REQ-014 FSM SHALL have exactly three states: IDLE, EXEC, RESP.
REQ-015 IDLE: if any reqN_valid, grant one requester, assert its reqN_ready for that cycle only, latch its a/b/op and id, go to EXEC; else stay IDLE.
REQ-016 reqN_ready SHALL be asserted only in IDLE, only to the granted requester, and only when its reqN_valid is high; never both in one cycle.
REQ-017 Arbitration SHALL be round-robin: if both valid, grant the requester not granted most recently; if one valid, grant it regardless of history.
REQ-018 EXEC: register ALU result and flags into rsp_result/rsp_nzvc, copy latched id into rsp_id, go to RESP (one cycle).
REQ-019 RESP: rsp_valid SHALL be high; rsp_result/rsp_nzvc/rsp_id SHALL stay stable until rsp_valid & rsp_ready, then return to IDLE.
REQ-020 Latency: handshake at cycle t -> rsp_valid high at t+2; with rsp_ready held high, next grant possible at t+3 (max throughput one op per 3 cycles).
REQ-021 Back-pressure: while rsp_ready low in RESP, no new request SHALL be accepted and reqN_ready stays low.
REQ-022 Request inputs changing while not granted SHALL have no effect; latched operands SHALL not change outside the accept cycle.
REQ-023 rsp_valid and reqN_ready SHALL be registered/state-decoded, with no combinational path from rsp_ready to reqN_ready.

Reset
REQ-024 On rst_n low, immediately (no clock): state=IDLE, rsp_valid=0, req0_ready=req1_ready=0, rsp_result=8'h00, rsp_nzvc=4'h0, rsp_id=0, latched operands/op=0.
REQ-025 Last-grant pointer SHALL reset to requester 1 so requester 0 wins the first contended cycle.
REQ-026 Reset mid-EXEC or mid-RESP SHALL discard the in-flight operation; no response emitted after release.

Structure
REQ-027 Shared package alu_pkg SHALL hold DATA_W=8, OP_W=3, FLAG_W=4 and the state encodings IDLE/EXEC/RESP.
REQ-028 Exactly one sub-module: the existing ALU (result, nzvc, a, b, op), instantiated once.
REQ-029 Target size 120-250 lines RTL excluding the ALU.

Verification
REQ-030 Single op: req0 op 3'b000, a=8'h01, b=8'h01, rsp_ready=1 -> req0_ready 1 cycle, rsp_valid at t+2, rsp_result=8'h02, rsp_nzvc=4'b0000, rsp_id=0.
REQ-031 Contention: both valid from reset, rsp_ready=1 -> grants alternate 0,1,0,1; rsp_id sequence 0,1,0,1.
REQ-032 Back-pressure: rsp_ready=0 for 5 cycles in RESP with req1_valid=1 -> rsp_* stable, req1_ready=0 throughout; req1 granted first IDLE cycle after release.
REQ-033 Operand hold: change req0_a after accept -> rsp_result reflects value latched at accept.
REQ-034 Reset mid-RESP: deassert rst_n with rsp_valid=1 -> rsp_valid=0 immediately, state IDLE, no response after release.
REQ-035 Single requester streaming: only req1 valid for 4 ops -> all granted to 1, 3-cycle spacing, rsp_id=1 each.
